// File: rtl/error_injector_if.sv
// Memory-side bus between requester and array, with the (possibly corrupted) data returns.
interface error_injector_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
);
   logic                  mem_access;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_wdata_out;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] mem_rdata_out;

   modport master (
      output mem_access, mem_addr, mem_we, mem_wdata, mem_rdata,
      input  mem_wdata_out, mem_rdata_out
   );

   modport slave (
      input  mem_access, mem_addr, mem_we, mem_wdata, mem_rdata,
      output mem_wdata_out, mem_rdata_out
   );
endinterface

// File: rtl/error_injector.sv
// error_injector: XOR fault-injection shim; zero-latency data path, no backpressure, registered status.
// Optional RANDOM mode (9, LFSR-driven pattern) is built only when ERRINJ_RANDOM_EN is defined.
module error_injector #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   error_injector_if.slave       bus,
   input  logic                  inject_enable,
   input  logic [3:0]            inject_mode,
   input  logic [ADDR_WIDTH-1:0] inject_addr,
   input  logic [15:0]           inject_mask,
   input  logic [31:0]           inject_count,
   input  logic                  inject_trigger,
   output logic                  single_error_inject,
   output logic                  double_error_inject,
   output logic                  burst_error_inject,
   output logic                  address_error_inject,
   output logic                  control_error_inject,
   output logic [31:0]           injection_count,
   output logic                  injection_active,
   output logic [ADDR_WIDTH-1:0] last_inject_addr
);
   localparam logic [3:0] MODE_SINGLE   = 4'd1;
   localparam logic [3:0] MODE_DOUBLE   = 4'd2;
   localparam logic [3:0] MODE_BURST    = 4'd3;
   localparam logic [3:0] MODE_ADDRESS  = 4'd4;
   localparam logic [3:0] MODE_CONTROL  = 4'd5;
   localparam logic [3:0] MODE_TARGETED = 4'd8;
`ifdef ERRINJ_RANDOM_EN
   localparam logic [3:0] MODE_RANDOM   = 4'd9;
`endif
   localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   logic [3:0]            low_bit;
   logic [DATA_WIDTH-1:0] pattern;
   logic                  mode_ok;
   logic                  addr_ok;
   logic                  under_limit;
   logic                  inject_now;
   logic [4:0]            flag_sel;
   logic [4:0]            flags;

`ifdef ERRINJ_RANDOM_EN
   logic [15:0] lfsr;
   logic [15:0] random_bits;

   assign random_bits = lfsr & inject_mask;

   // Fibonacci taps 16,14,13,11; advances only when an injection actually fires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= 16'hACE1;
      end else if (inject_now) begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end
`endif

   // Scan downward so the lowest set bit wins; an all-zero mask leaves bit 0
   always_comb begin
      low_bit = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (inject_mask[i]) low_bit = i[3:0];
      end
   end

   always_comb begin
      pattern  = '0;
      mode_ok  = 1'b1;
      flag_sel = 5'b00000;
      case (inject_mode)
         MODE_SINGLE, MODE_TARGETED: begin
            pattern  = ONE << low_bit;
            flag_sel = 5'b00001;
         end
         MODE_DOUBLE: begin
            pattern  = (ONE << low_bit) | (ONE << ({1'b0, low_bit} + 5'd1));
            flag_sel = 5'b00010;
         end
         MODE_BURST: begin
            for (int i = 0; i < DATA_WIDTH; i++) pattern[i] = inject_mask[i[3:0]];
            flag_sel = 5'b00100;
         end
         MODE_ADDRESS: begin
            flag_sel = 5'b01000;
         end
         MODE_CONTROL: begin
            pattern[DATA_WIDTH-1] = 1'b1;
            flag_sel              = 5'b10000;
         end
`ifdef ERRINJ_RANDOM_EN
         MODE_RANDOM: begin
            if (random_bits != 16'd0) pattern[15:0] = random_bits;
            else                      pattern       = ONE << low_bit;
            flag_sel = 5'b00100;
         end
`endif
         default: begin
            mode_ok = 1'b0;
         end
      endcase
   end

   assign addr_ok     = (inject_mode != MODE_TARGETED) || (bus.mem_addr == inject_addr);
   assign under_limit = (inject_count == 32'd0) || (injection_count < inject_count);
   assign inject_now  = bus.mem_access && inject_enable && inject_trigger &&
                        mode_ok && addr_ok && under_limit;

   assign bus.mem_wdata_out = bus.mem_wdata ^ ((inject_now &&  bus.mem_we) ? pattern : '0);
   assign bus.mem_rdata_out = bus.mem_rdata ^ ((inject_now && !bus.mem_we) ? pattern : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags            <= 5'b00000;
         injection_count  <= 32'd0;
         injection_active <= 1'b0;
         last_inject_addr <= '0;
      end else if (!inject_enable) begin
         flags            <= 5'b00000;
         injection_active <= 1'b0;
      end else if (inject_now) begin
         if (injection_count != 32'hFFFF_FFFF) injection_count <= injection_count + 32'd1;
         last_inject_addr <= bus.mem_addr;
         injection_active <= 1'b1;
         flags            <= flag_sel;
      end else if (bus.mem_access) begin
         flags <= 5'b00000;
      end
   end

   assign {control_error_inject, address_error_inject, burst_error_inject,
           double_error_inject, single_error_inject} = flags;
endmodule

// File: tb/tb_error_injector.sv
// Directed table-driven bench for error_injector plus hand-written reset sequence.
module tb_error_injector;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        inject_enable;
   logic [3:0]  inject_mode;
   logic [31:0] inject_addr;
   logic [15:0] inject_mask;
   logic [31:0] inject_count;
   logic        inject_trigger;
   logic        single_error_inject, double_error_inject, burst_error_inject;
   logic        address_error_inject, control_error_inject;
   logic [31:0] injection_count;
   logic        injection_active;
   logic [31:0] last_inject_addr;

   int n_total = 0;
   int n_pass  = 0;

   error_injector_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

   error_injector #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .bus                  (bus),
      .inject_enable        (inject_enable),
      .inject_mode          (inject_mode),
      .inject_addr          (inject_addr),
      .inject_mask          (inject_mask),
      .inject_count         (inject_count),
      .inject_trigger       (inject_trigger),
      .single_error_inject  (single_error_inject),
      .double_error_inject  (double_error_inject),
      .burst_error_inject   (burst_error_inject),
      .address_error_inject (address_error_inject),
      .control_error_inject (control_error_inject),
      .injection_count      (injection_count),
      .injection_active     (injection_active),
      .last_inject_addr     (last_inject_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [3:0]  mode;
      logic [31:0] iaddr;
      logic [15:0] mask;
      logic [31:0] cnt;
      logic        trig;
      logic        acc;
      logic [31:0] addr;
      logic        we;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic [63:0] e_wout;
      logic [63:0] e_rout;
      logic [4:0]  e_flags;   // {control,address,burst,double,single}
      logic        e_act;
      logic [31:0] e_count;
      logic [31:0] e_last;
   } vec_t;

   vec_t vecs[22];

   function automatic vec_t mk(logic en, logic [3:0] mode, logic [31:0] iaddr, logic [15:0] mask,
                               logic [31:0] cnt, logic trig, logic acc, logic [31:0] addr, logic we,
                               logic [63:0] wdata, logic [63:0] rdata, logic [63:0] e_wout,
                               logic [63:0] e_rout, logic [4:0] e_flags, logic e_act,
                               logic [31:0] e_count, logic [31:0] e_last);
      vec_t v;
      v.en = en; v.mode = mode; v.iaddr = iaddr; v.mask = mask; v.cnt = cnt; v.trig = trig;
      v.acc = acc; v.addr = addr; v.we = we; v.wdata = wdata; v.rdata = rdata;
      v.e_wout = e_wout; v.e_rout = e_rout; v.e_flags = e_flags; v.e_act = e_act;
      v.e_count = e_count; v.e_last = e_last;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [4:0] flag_vec();
      return {control_error_inject, address_error_inject, burst_error_inject,
              double_error_inject, single_error_inject};
   endfunction

   task automatic drive(input vec_t v);
      inject_enable  = v.en;
      inject_mode    = v.mode;
      inject_addr    = v.iaddr;
      inject_mask    = v.mask;
      inject_count   = v.cnt;
      inject_trigger = v.trig;
      bus.mem_access = v.acc;
      bus.mem_addr   = v.addr;
      bus.mem_we     = v.we;
      bus.mem_wdata  = v.wdata;
      bus.mem_rdata  = v.rdata;
   endtask

   initial begin
      //            en mode iaddr      mask     cnt trg acc addr       we wdata                  rdata                   e_wout                  e_rout                  flags    act cnt last
      vecs[0]  = mk(1, 1, 32'h0,   16'h0001, 0, 1, 1, 32'h100, 1, 64'hDEADBEEFCAFEBABE, 64'h0, 64'hDEADBEEFCAFEBABF, 64'h0, 5'b00001, 1, 1, 32'h100);
      vecs[1]  = mk(1, 8, 32'h200, 16'h0002, 0, 1, 1, 32'h200, 0, 64'h0, 64'h0, 64'h0, 64'h2, 5'b00001, 1, 2, 32'h200);
      vecs[2]  = mk(1, 8, 32'h200, 16'h0002, 0, 1, 1, 32'h204, 0, 64'h0, 64'h0, 64'h0, 64'h0, 5'b00000, 1, 2, 32'h200);
      vecs[3]  = mk(1, 2, 32'h0,   16'h0010, 4, 1, 1, 32'h300, 1, 64'h0, 64'h0, 64'h30, 64'h0, 5'b00010, 1, 3, 32'h300);
      vecs[4]  = mk(1, 2, 32'h0,   16'h0010, 4, 1, 1, 32'h304, 1, 64'h0, 64'h0, 64'h30, 64'h0, 5'b00010, 1, 4, 32'h304);
      vecs[5]  = mk(1, 2, 32'h0,   16'h0010, 4, 1, 1, 32'h308, 1, 64'h0, 64'h0, 64'h0,  64'h0, 5'b00000, 1, 4, 32'h304);
      vecs[6]  = mk(1, 2, 32'h0,   16'h0010, 5, 1, 1, 32'h30C, 1, 64'h0, 64'h0, 64'h30, 64'h0, 5'b00010, 1, 5, 32'h30C);
      vecs[7]  = mk(1, 3, 32'h0,   16'h00FF, 0, 1, 1, 32'h400, 1, 64'h0, 64'h0, 64'h00FF00FF00FF00FF, 64'h0, 5'b00100, 1, 6, 32'h400);
      vecs[8]  = mk(1, 3, 32'h0,   16'h8001, 0, 1, 1, 32'h404, 0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h7FFE7FFE7FFE7FFE, 5'b00100, 1, 7, 32'h404);
      vecs[9]  = mk(1, 4, 32'h0,   16'h000F, 0, 1, 1, 32'h500, 1, 64'h1234, 64'h0, 64'h1234, 64'h0, 5'b01000, 1, 8, 32'h500);
      vecs[10] = mk(1, 5, 32'h0,   16'h0001, 0, 1, 1, 32'h504, 0, 64'h0, 64'h0, 64'h0, 64'h8000000000000000, 5'b10000, 1, 9, 32'h504);
      vecs[11] = mk(1, 1, 32'h0,   16'h0000, 0, 1, 1, 32'h600, 1, 64'h0, 64'h0, 64'h1, 64'h0, 5'b00001, 1, 10, 32'h600);
      vecs[12] = mk(1, 1, 32'h0,   16'hA000, 0, 1, 1, 32'h604, 1, 64'h0, 64'h0, 64'h2000, 64'h0, 5'b00001, 1, 11, 32'h604);
      vecs[13] = mk(1, 2, 32'h0,   16'h8000, 0, 1, 1, 32'h608, 1, 64'h0, 64'h0, 64'h18000, 64'h0, 5'b00010, 1, 12, 32'h608);
      vecs[14] = mk(1, 1, 32'h0,   16'h0001, 0, 0, 1, 32'h60C, 1, 64'h0, 64'h0, 64'h0, 64'h0, 5'b00000, 1, 12, 32'h608);
      vecs[15] = mk(1, 1, 32'h0,   16'h0001, 0, 1, 1, 32'h700, 1, 64'h0, 64'h0, 64'h1, 64'h0, 5'b00001, 1, 13, 32'h700);
      vecs[16] = mk(1, 1, 32'h0,   16'h0001, 0, 1, 0, 32'h704, 1, 64'h55, 64'h0, 64'h55, 64'h0, 5'b00001, 1, 13, 32'h700);
      vecs[17] = mk(1, 6, 32'h0,   16'h0001, 0, 1, 1, 32'h708, 1, 64'h0, 64'h0, 64'h0, 64'h0, 5'b00000, 1, 13, 32'h700);
      vecs[18] = mk(1, 1, 32'h0,   16'h0001, 0, 1, 1, 32'h710, 1, 64'h0, 64'h0, 64'h1, 64'h0, 5'b00001, 1, 14, 32'h710);
      vecs[19] = mk(0, 1, 32'h0,   16'h0001, 0, 1, 1, 32'h714, 1, 64'hF0, 64'h0, 64'hF0, 64'h0, 5'b00000, 0, 14, 32'h710);
      vecs[20] = mk(0, 1, 32'h0,   16'h0001, 0, 1, 1, 32'h718, 0, 64'h0, 64'hAA, 64'h0, 64'hAA, 5'b00000, 0, 14, 32'h710);
      vecs[21] = mk(1, 0, 32'h0,   16'h0001, 0, 1, 1, 32'h71C, 1, 64'h99, 64'h0, 64'h99, 64'h0, 5'b00000, 0, 14, 32'h710);

      rst_n = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 64'h0, 5'b0, 0, 0, 0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_flags",  {59'd0, flag_vec()}, 64'h0);
      chk("reset_active", {63'd0, injection_active}, 64'h0);
      chk("reset_count",  {32'd0, injection_count}, 64'h0);
      chk("reset_last",   {32'd0, last_inject_addr}, 64'h0);

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d_wdata_out", i), bus.mem_wdata_out, vecs[i].e_wout);
         chk($sformatf("v%0d_rdata_out", i), bus.mem_rdata_out, vecs[i].e_rout);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_flags", i),  {59'd0, flag_vec()}, {59'd0, vecs[i].e_flags});
         chk($sformatf("v%0d_active", i), {63'd0, injection_active}, {63'd0, vecs[i].e_act});
         chk($sformatf("v%0d_count", i),  {32'd0, injection_count}, {32'd0, vecs[i].e_count});
         chk($sformatf("v%0d_last", i),   {32'd0, last_inject_addr}, {32'd0, vecs[i].e_last});
      end

      // Reset asserted in the middle of an armed write must clear registers asynchronously
      @(negedge clk);
      drive(mk(1, 1, 0, 16'h0001, 0, 1, 1, 32'h800, 1, 64'h0, 64'h0, 64'h0, 64'h0, 5'b0, 0, 0, 0));
      rst_n = 1'b0;
      #1;
      chk("midrst_flags",  {59'd0, flag_vec()}, 64'h0);
      chk("midrst_active", {63'd0, injection_active}, 64'h0);
      chk("midrst_count",  {32'd0, injection_count}, 64'h0);
      chk("midrst_last",   {32'd0, last_inject_addr}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_access = 1'b0;
      bus.mem_wdata  = 64'h77;
      #1;
      chk("postrst_passthru", bus.mem_wdata_out, 64'h77);
      @(posedge clk);
      #1;
      chk("postrst_count_idle", {32'd0, injection_count}, 64'h0);
      @(negedge clk);
      bus.mem_access = 1'b1;
      bus.mem_addr   = 32'h900;
      bus.mem_wdata  = 64'h0;
      #1;
      chk("postrst_inject_wout", bus.mem_wdata_out, 64'h1);
      @(posedge clk);
      #1;
      chk("postrst_count",  {32'd0, injection_count}, 64'h1);
      chk("postrst_last",   {32'd0, last_inject_addr}, 64'h900);
      chk("postrst_active", {63'd0, injection_active}, 64'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/error_injector.md
Name: error_injector

Overview:
- Fault-injection shim between a memory requester and a memory array, used for ECC and error-handling verification.
- Passes write data to the array and read data back to the requester. When armed, it XOR-corrupts the data of qualifying accesses with a mode-dependent error pattern.
- Registered status flags report the injection type, and a counter and last-address record give observability.

Parameters:
- ADDR_WIDTH, 32, width of memory address and target address.
- DATA_WIDTH, 64, width of memory data words (must be >= 16).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- inject_enable  in  1  master enable; low clears flags and injection_active.
- inject_mode  in  4  error type select (encodings below).
- inject_addr  in  ADDR_WIDTH  target address for TARGETED mode.
- inject_mask  in  16  bit mask seeding the error pattern.
- inject_count  in  32  injection limit; 0 = unlimited.
- inject_trigger  in  1  level arm; injection is allowed while high.
- mem_access  in  1  access strobe, one cycle per access.
- mem_addr  in  ADDR_WIDTH  access address.
- mem_we  in  1  1 = write, 0 = read.
- mem_wdata  in  DATA_WIDTH  write data from requester.
- mem_wdata_out  out  DATA_WIDTH  write data to memory, possibly corrupted.
- mem_rdata  in  DATA_WIDTH  read data from memory.
- mem_rdata_out  out  DATA_WIDTH  read data to requester, possibly corrupted.
- single_error_inject  out  1  last injection was single-bit or targeted.
- double_error_inject  out  1  last injection was double-bit.
- burst_error_inject  out  1  last injection was burst.
- address_error_inject  out  1  last injection was address type.
- control_error_inject  out  1  last injection was control type.
- injection_count  out  32  total injections since reset.
- injection_active  out  1  an injection occurred and enable is still high.
- last_inject_addr  out  ADDR_WIDTH  mem_addr of the most recent injection.

Behaviour:
- Mode encodings: 0 NONE, 1 SINGLE_BIT, 2 DOUBLE_BIT, 3 BURST, 4 ADDRESS, 5 CONTROL, 8 TARGETED. Any other value behaves as NONE.
- inject_now (combinational) = mem_access & inject_enable & inject_trigger & mode != NONE & (inject_count == 0 | injection_count < inject_count). In TARGETED mode it additionally requires mem_addr == inject_addr.
- Let L = index of the lowest set bit of inject_mask, or 0 if the mask is zero. Error pattern P by mode:
  - SINGLE_BIT and TARGETED: only bit L set.
  - DOUBLE_BIT: bits L and (L+1) set.
  - BURST: inject_mask replicated across DATA_WIDTH, LSB-aligned, truncated at the top.
  - ADDRESS: P = 0; data is unchanged and the fault is reported via the flag only.
  - CONTROL: only bit DATA_WIDTH-1 set.
- Data path, zero latency, combinational:
  - mem_wdata_out = mem_wdata ^ (inject_now & mem_we ? P : 0).
  - mem_rdata_out = mem_rdata ^ (inject_now & ~mem_we ? P : 0).
  - mem_rdata is corrupted in the same cycle as the read strobe; the memory returns read data combinationally.
- Registered state, updated on the rising clk edge:
  - On an inject_now cycle: injection_count increments, saturating at 32'hFFFFFFFF. last_inject_addr <= mem_addr. injection_active <= 1. Exactly the one type flag for the mode is set and all other flags are cleared.
  - On a mem_access cycle without injection: all type flags are cleared; injection_active is held.
  - With no access: everything is held.
  - inject_enable low: all type flags and injection_active are cleared. injection_count and last_inject_addr are held.
- Reset: all outputs that are registers are 0. The data outputs are pure pass-through.
- Count limit: once injection_count == inject_count (nonzero), further accesses pass through unmodified. Changing inject_count at runtime takes effect immediately.

Optional Feature:
- Macro ERRINJ_RANDOM_EN.
- Defined: mode 9 = RANDOM. A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances on every inject_now cycle. The pattern is the LFSR value ANDed with inject_mask, placed in the low 16 bits; if that AND is zero, bit L is used instead. The burst_error_inject flag is set.
- Not defined: mode 9 behaves as NONE and no LFSR is built.

Test Plan:
- Single-bit write: enable=1, mode=1, mask=0x0001, trigger=1, count=0; write addr 0x100 data 0xDEADBEEFCAFEBABE -> mem_wdata_out = 0xDEADBEEFCAFEBABF in the access cycle; one cycle after the access, single_error_inject=1, injection_active=1, injection_count=1, last_inject_addr=0x100.
- Targeted read: mode=8, inject_addr=0x200, mask=0x0002, mem_rdata=0. Read 0x200 -> mem_rdata_out=0x2, then injection_active=1, last_inject_addr=0x200. Read 0x204 -> mem_rdata_out=0 and single_error_inject clears.
- Count limit: mode=2, mask=0x0010, count=2; three writes of 0 -> first two outputs are 0x30, third is 0; injection_count stays at 2.
- Burst: mode=3, mask=0x00FF; write 0 -> mem_wdata_out=0x00FF00FF00FF00FF and burst_error_inject=1, all other type flags 0.
- Gating: trigger=0 or enable=0 -> data passes unchanged. Dropping enable clears injection_active and all flags; injection_count is held.
- Reset mid-operation: assert rst_n low during an armed access -> all registered outputs read 0 immediately; the data path passes through after release.
